// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants for register addressing.
package cpu_pkg;
   localparam int          REG_ADDR_W = 5;
   localparam int          NUM_REGS   = 32;
   localparam logic [4:0]  REG_ZERO   = 5'd0;
endpackage

// File: rtl/dec5t32e.sv
// 5-to-32 decoder with enable; produces a one-hot select vector.
module DEC5T32E (
   input  logic [4:0]  I,
   input  logic        En,
   output logic [31:0] Y
);

   always_comb begin
      Y = '0;
      if (En) Y[I] = 1'b1;
   end

endmodule

// File: rtl/reg_file_32x32.sv
// 2R1W register file with a pending-write scoreboard for RAW hazard detection.
// Register 0 is hardwired to zero and can never become pending.
module reg_file_32x32
   import cpu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [REG_ADDR_W-1:0] RA1,
   input  logic [REG_ADDR_W-1:0] RA2,
   output logic [WIDTH-1:0]      RD1,
   output logic [WIDTH-1:0]      RD2,
   input  logic                  WE,
   input  logic [REG_ADDR_W-1:0] WA,
   input  logic [WIDTH-1:0]      WD,
   input  logic                  IssEn,
   input  logic [REG_ADDR_W-1:0] IssRd,
   output logic                  Hazard
);

   logic [NUM_REGS-1:0] we_dec;
   logic [NUM_REGS-1:0] iss_dec;
   logic [NUM_REGS-1:0] pend;
   logic [NUM_REGS-1:0] pend_nxt;
   logic [WIDTH-1:0]    regs [NUM_REGS];

   DEC5T32E u_wdec (
      .I  (WA),
      .En (WE),
      .Y  (we_dec)
   );

   assign iss_dec = {{(NUM_REGS-1){1'b0}}, IssEn} << IssRd;

   // Issue is OR'ed in after the clear so a re-issuing producer stays pending.
   // Bit 0 is masked so the zero register never tracks a write.
   assign pend_nxt = ((pend & ~we_dec) | iss_dec) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};

   always_ff @(posedge Clk) begin
      if (Rst) begin
         pend <= '0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      end else begin
         pend <= pend_nxt;
         for (int k = 1; k < NUM_REGS; k++) begin
            if (we_dec[k]) regs[k] <= WD;
         end
      end
   end

   function automatic logic fwd_hit(input logic [REG_ADDR_W-1:0] a);
      return BYPASS && WE && (WA == a);
   endfunction

   always_comb begin
      RD1 = '0;
      if (RA1 != REG_ZERO) begin
         if (fwd_hit(RA1) && !Rst) RD1 = WD;
         else                      RD1 = regs[RA1];
      end
   end

   always_comb begin
      RD2 = '0;
      if (RA2 != REG_ZERO) begin
         if (fwd_hit(RA2) && !Rst) RD2 = WD;
         else                      RD2 = regs[RA2];
      end
   end

   assign Hazard = (pend[RA1] && !fwd_hit(RA1)) || (pend[RA2] && !fwd_hit(RA2));

endmodule
